// File: rtl/am_demod_param.sv
// am_demod_param
// Parametrised AM demodulator. Each accepted sample is either multiplied by
// the DDS carrier (coherent) or full-wave rectified (envelope), averaged by a
// 2^AVG_LOG2-deep boxcar, optionally DC-stripped by a leaky integrator, and
// returned in offset binary. Latency is three clocks from acceptance to the
// out_valid strobe; one sample per clock.
//
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-high (wins over in_valid)
//   in_valid   sample strobe for sig_in/carrier/mode
//   sig_in     modulated input, offset binary
//   carrier    DDS carrier, offset binary (ignored in envelope mode)
//   mode       0 = coherent product, 1 = envelope
//   dc_remove  1 = subtract running DC estimate (taken with the stage-2 result)
//   out_valid  one-cycle strobe per demodulated sample
//   sig_out    demodulated sample, offset binary; holds between strobes
//   ovf        sticky saturation flag, cleared only by rst
module am_demod_param #(
  parameter int DW       = 16,
  parameter int AVG_LOG2 = 4,
  parameter int DC_SHIFT = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] sig_in,
  input  logic [DW-1:0] carrier,
  input  logic          mode,
  input  logic          dc_remove,
  output logic          out_valid,
  output logic [DW-1:0] sig_out,
  output logic          ovf
);

  localparam int D  = 1 << AVG_LOG2;
  localparam int AW = DW + AVG_LOG2;
  localparam int CW = AVG_LOG2 + 1;
  // DC estimate carries DC_SHIFT fraction bits plus headroom for the
  // (target - estimate) difference.
  localparam int W3 = DW + DC_SHIFT + 2;
  localparam int YW = DW + 3;

  localparam logic signed [DW-1:0] SMAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] SMIN = {1'b1, {(DW-1){1'b0}}};

  // ---------------- stage 1: product / rectify ----------------
  logic signed [DW-1:0] s_in, c_in, r_c;
  logic                 sat_c, restart_c, warm_c;
  logic [CW-1:0]        cnt, cnt_next;
  logic                 last_mode;

  logic signed [DW-1:0] r1;
  logic                 v1, restart1, warm1;

  assign s_in = {~sig_in[DW-1], sig_in[DW-2:0]};
  assign c_in = {~carrier[DW-1], carrier[DW-2:0]};

  always_comb begin
    r_c   = '0;
    sat_c = 1'b0;
    if (!mode) begin
      // Only full-scale negative squared leaves the Q1 range.
      if (s_in == SMIN && c_in == SMIN) begin
        r_c   = SMAX;
        sat_c = 1'b1;
      end else begin
        r_c = DW'(((2*DW)'(s_in) * (2*DW)'(c_in)) >>> (DW-1));
      end
    end else begin
      if (s_in == SMIN) begin
        r_c   = SMAX;
        sat_c = 1'b1;
      end else if (s_in[DW-1]) begin
        r_c = -s_in;
      end else begin
        r_c = s_in;
      end
    end
  end

  assign restart_c = (mode != last_mode);

  always_comb begin
    if (restart_c)
      cnt_next = CW'(1);
    else if (cnt == CW'(D))
      cnt_next = cnt;
    else
      cnt_next = cnt + CW'(1);
  end

  assign warm_c = (cnt_next == CW'(D));

  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      r1        <= '0;
      restart1  <= 1'b0;
      warm1     <= 1'b0;
      last_mode <= 1'b0;
      cnt       <= '0;
    end else begin
      v1 <= in_valid;
      if (in_valid) begin
        r1        <= r_c;
        restart1  <= restart_c;
        warm1     <= warm_c;
        last_mode <= mode;
        cnt       <= cnt_next;
      end
    end
  end

  // ---------------- stage 2: boxcar ----------------
  logic signed [DW-1:0]   bx [D];
  logic [AVG_LOG2-1:0]    wp;
  logic signed [AW-1:0]   acc, acc_next;
  logic signed [DW-1:0]   a2;
  logic                   v2, warm2, restart2, dc_remove2;

  // On restart the old buffer contents are treated as zero, so the new
  // sample alone seeds the accumulator.
  assign acc_next = restart1 ? AW'(r1) : (acc + AW'(r1) - AW'(bx[wp]));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < D; i++) bx[i] <= '0;
      wp         <= '0;
      acc        <= '0;
      a2         <= '0;
      v2         <= 1'b0;
      warm2      <= 1'b0;
      restart2   <= 1'b0;
      dc_remove2 <= 1'b0;
    end else begin
      v2 <= v1;
      if (v1) begin
        if (restart1) begin
          for (int i = 0; i < D; i++) bx[i] <= '0;
        end
        bx[wp]     <= r1;
        wp         <= wp + AVG_LOG2'(1);
        acc        <= acc_next;
        a2         <= acc_next[AW-1:AVG_LOG2];
        warm2      <= warm1;
        restart2   <= restart1;
        dc_remove2 <= dc_remove;
      end
    end
  end

  // ---------------- stage 3: DC removal ----------------
  logic signed [W3-1:0]   dc, dc_cur, dc_tgt, dc_next;
  logic signed [DW+1:0]   dc_int;
  logic signed [YW-1:0]   y_diff;
  logic signed [DW-1:0]   y_sat, y3;
  logic                   sat3, v3;

  assign dc_cur  = restart2 ? '0 : dc;
  assign dc_int  = dc_cur[W3-1:DC_SHIFT];
  assign dc_tgt  = W3'(a2) <<< DC_SHIFT;
  assign dc_next = dc_cur + ((dc_tgt - dc_cur) >>> DC_SHIFT);
  assign y_diff  = YW'(a2) - YW'(dc_int);

  always_comb begin
    sat3  = 1'b0;
    y_sat = y_diff[DW-1:0];
    if (y_diff > YW'(SMAX)) begin
      y_sat = SMAX;
      sat3  = 1'b1;
    end else if (y_diff < YW'(SMIN)) begin
      y_sat = SMIN;
      sat3  = 1'b1;
    end
  end

  // The estimate only follows averaged (warm) samples, so the first real
  // output always sees a zero estimate.
  always_ff @(posedge clk) begin
    if (rst) begin
      dc <= '0;
      y3 <= '0;
      v3 <= 1'b0;
    end else begin
      v3 <= v2 & warm2;
      if (v2) begin
        dc <= warm2 ? dc_next : dc_cur;
        y3 <= dc_remove2 ? y_sat : a2;
      end
    end
  end

  // ---------------- output ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      sig_out   <= {1'b1, {(DW-1){1'b0}}};
    end else begin
      out_valid <= v3;
      if (v3) sig_out <= {~y3[DW-1], y3[DW-2:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      ovf <= 1'b0;
    else if ((in_valid && sat_c) || (v2 && warm2 && dc_remove2 && sat3))
      ovf <= 1'b1;
  end

endmodule

// File: tb/tb_am_demod_param.sv
// tb_am_demod_param
// Directed bench for am_demod_param (DW=16, AVG_LOG2=2, DC_SHIFT=10).
// A behavioural model predicts every output when a sample is driven and
// queues value plus expected edge; a negedge monitor pops and compares.
module tb_am_demod_param;

  localparam int DW = 16;
  localparam int AL = 2;
  localparam int DS = 10;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          rst, in_valid, mode, dc_remove;
  logic [DW-1:0] sig_in, carrier;
  logic          out_valid, ovf;
  logic [DW-1:0] sig_out;

  am_demod_param #(.DW(DW), .AVG_LOG2(AL), .DC_SHIFT(DS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .sig_in(sig_in),
    .carrier(carrier), .mode(mode), .dc_remove(dc_remove),
    .out_valid(out_valid), .sig_out(sig_out), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int n_out  = 0;
  logic [15:0] last_out = 16'h8000;
  bit track_mono = 0;
  bit mono_bad   = 0;

  typedef struct { logic [15:0] val; int at; } exp_t;
  exp_t q[$];

  // model state
  int m_last_mode, m_wp, m_acc, m_cnt, m_dc;
  int m_buf [D];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_last_mode = 0; m_wp = 0; m_acc = 0; m_cnt = 0; m_dc = 0;
    for (int i = 0; i < D; i++) m_buf[i] = 0;
    q.delete();
  endtask

  task automatic model_sample(input logic [15:0] si, input logic [15:0] ci,
                              input logic md, input logic dcr, input int at);
    logic signed [15:0] ts, tc;
    int s, c, r, a, y, dci;
    longint p;
    exp_t e;
    ts = si ^ 16'h8000; tc = ci ^ 16'h8000;
    s = ts; c = tc;
    if (!md) begin
      p = longint'(s) * longint'(c);
      r = int'(p >>> 15);
    end else begin
      r = (s < 0) ? -s : s;
    end
    if (r > 32767) r = 32767;
    if (int'(md) != m_last_mode) begin
      for (int i = 0; i < D; i++) m_buf[i] = 0;
      m_buf[m_wp] = r; m_acc = r; m_cnt = 0; m_dc = 0; m_last_mode = int'(md);
    end else begin
      m_acc = m_acc + r - m_buf[m_wp];
      m_buf[m_wp] = r;
    end
    m_wp = (m_wp + 1) % D;
    if (m_cnt < D) m_cnt++;
    if (m_cnt == D) begin
      a   = m_acc >>> AL;
      dci = m_dc >>> DS;
      if (dcr) begin
        y = a - dci;
        if (y > 32767) y = 32767;
        if (y < -32768) y = -32768;
      end else begin
        y = a;
      end
      m_dc = m_dc + (((a <<< DS) - m_dc) >>> DS);
      e.val = 16'(y) ^ 16'h8000;
      e.at  = at + 3;
      q.push_back(e);
    end
  endtask

  task automatic step(input bit v, input logic [15:0] si, input logic [15:0] ci, input logic md);
    in_valid = v; sig_in = si; carrier = ci; mode = md;
    @(posedge clk); #1;
    if (v) model_sample(si, ci, md, dc_remove, cyc);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h1234, 16'h4321, mode);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;
  endtask

  task automatic check_drained(input string tag);
    idle(5);
    chk(tag, q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      exp_t e;
      n_out++;
      checks++;
      assert (q.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_out_valid cycle=%0d observed=%h expected=no output", cyc, sig_out);
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        assert (sig_out === e.val) else begin
          errors++;
          $error("FAIL sig_out observed=%h expected=%h", sig_out, e.val);
        end
        checks++;
        assert (cyc === e.at) else begin
          errors++;
          $error("FAIL out_timing observed=%0d expected=%0d", cyc, e.at);
        end
      end
      if (track_mono && sig_out > last_out) mono_bad = 1;
      last_out = sig_out;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n0;
    rst = 1'b1; in_valid = 1'b0; mode = 1'b0; dc_remove = 1'b0;
    sig_in = '0; carrier = '0;
    model_reset();

    // 1: reset state, lone sample never completes warm-up
    do_reset(2);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sig_out", sig_out, 16'h8000);
    chk("rst_ovf", ovf, 0);
    n0 = n_out;
    step(1'b1, 16'h8000, 16'h8000, 1'b0);
    idle(6);
    chk("t1_no_output", n_out - n0, 0);

    // 2: coherent DC
    do_reset(1);
    n0 = n_out;
    for (int i = 0; i < 6; i++) step(1'b1, 16'hC000, 16'hC000, 1'b0);
    idle(5);
    chk("t2_count", n_out - n0, 3);
    chk("t2_value", last_out, 16'hA000);
    chk("t2_ovf", ovf, 0);
    check_drained("t2_drained");

    // 5: mode restart from coherent steady state
    n0 = n_out;
    for (int i = 0; i < 3; i++) step(1'b1, 16'hC000, 16'($urandom), 1'b1);
    idle(5);
    chk("t5_warmup_silent", n_out - n0, 0);
    step(1'b1, 16'hC000, 16'($urandom), 1'b1);
    idle(5);
    chk("t5_count", n_out - n0, 1);
    chk("t5_value", last_out, 16'hC000);

    // 3: coherent saturation, sticky ovf
    do_reset(1);
    for (int i = 0; i < 4; i++) step(1'b1, 16'h0000, 16'h0000, 1'b0);
    idle(5);
    chk("t3_value", last_out, 16'hFFFF);
    chk("t3_ovf_set", ovf, 1);
    for (int i = 0; i < 4; i++) step(1'b1, 16'h8000, 16'h8000, 1'b0);
    idle(5);
    chk("t3_ovf_sticky", ovf, 1);
    check_drained("t3_drained");

    // 4: envelope with bubbles
    do_reset(1);
    n0 = n_out;
    for (int i = 0; i < 8; i++) begin
      while ($urandom_range(0, 2) == 0) step(1'b0, 16'h5555, 16'h1111, 1'b1);
      step(1'b1, (i % 2 == 1) ? 16'h4000 : 16'hC000, 16'($urandom), 1'b1);
    end
    idle(5);
    chk("t4_count", n_out - n0, 5);
    chk("t4_value", last_out, 16'hC000);
    chk("t4_ovf_clear", ovf, 0);
    // envelope of negative full scale saturates
    step(1'b1, 16'h0000, 16'h0000, 1'b1);
    idle(5);
    chk("t4_env_sat_value", last_out, 16'hCFFF);
    chk("t4_env_sat_ovf", ovf, 1);

    // 6: DC removal over a long run, then reset mid-pipeline
    do_reset(1);
    dc_remove = 1'b1;
    n0 = n_out;
    for (int i = 0; i < 4; i++) step(1'b1, 16'hC000, 16'hC000, 1'b0);
    idle(4);
    chk("t6_first", last_out, 16'hA000);
    track_mono = 1;
    for (int i = 4; i < 4096; i++) step(1'b1, 16'hC000, 16'hC000, 1'b0);
    idle(5);
    track_mono = 0;
    chk("t6_count", n_out - n0, 4093);
    chk("t6_monotonic", mono_bad, 0);
    chk("t6_decayed", (last_out < 16'h8200) ? 1 : 0, 1);
    check_drained("t6_drained");

    n0 = n_out;
    step(1'b1, 16'hC000, 16'hC000, 1'b0);
    do_reset(1);
    idle(6);
    chk("t6_rst_suppressed", n_out - n0, 0);
    chk("t6_rst_out_valid", out_valid, 0);
    chk("t6_rst_sig_out", sig_out, 16'h8000);
    chk("t6_rst_ovf", ovf, 0);
    for (int i = 0; i < 4; i++) step(1'b1, 16'hC000, 16'hC000, 1'b0);
    idle(5);
    chk("t6_post_rst_count", n_out - n0, 1);
    chk("t6_post_rst_value", last_out, 16'hA000);
    check_drained("final_drained");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
